// File: rtl/regs_operand_fetch_pkg.sv
// Shared widths, RV32I opcodes and the operand-fetch FSM encoding.
package regs_operand_fetch_pkg;

  localparam int REG_W  = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  function automatic logic f_use_rs1(input logic [6:0] opc);
    return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  endfunction

  function automatic logic f_use_rs2(input logic [6:0] opc);
    return (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/regs_operand_fetch_operand_resolve.sv
// One operand's value tracking: accept-edge bypass capture, READ-cycle
// priority select and VALID-state write-back snoop.
module operand_resolve
  import regs_operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_accept,
  input  logic [REG_AW-1:0] i_acc_rs,
  input  logic              i_load,
  input  logic              i_snoop,
  input  logic [REG_AW-1:0] i_rs,
  input  logic              i_use,
  input  logic [REG_W-1:0]  i_rdata,
  input  logic              i_wb_we,
  input  logic [REG_AW-1:0] i_wb_waddr,
  input  logic [REG_W-1:0]  i_wb_wdata,
  output logic [REG_W-1:0]  o_data
);

  logic             r_byp;
  logic [REG_W-1:0] r_byp_data;
  logic [REG_W-1:0] r_data;
  logic             w_acc_hit;
  logic             w_live;
  logic             w_wb_hit;

  // The regfile returns the pre-write value when written on the accept edge.
  assign w_acc_hit = i_wb_we && (i_wb_waddr == i_acc_rs) && (i_acc_rs != '0);
  assign w_live    = i_use && (i_rs != '0);
  assign w_wb_hit  = i_wb_we && (i_wb_waddr == i_rs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byp      <= 1'b0;
      r_byp_data <= '0;
      r_data     <= '0;
    end else begin
      if (i_accept) begin
        r_byp <= w_acc_hit;
        if (w_acc_hit) r_byp_data <= i_wb_wdata;
      end
      if (i_load) begin
        if (!w_live)       r_data <= '0;
        else if (w_wb_hit) r_data <= i_wb_wdata;
        else if (r_byp)    r_data <= r_byp_data;
        else               r_data <= i_rdata;
      end else if (i_snoop && w_live && w_wb_hit) begin
        r_data <= i_wb_wdata;
      end
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/regs_operand_fetch.sv
// Operand fetch stage: reads rs1/rs2 from the regfile and presents
// write-back-corrected operands to execute under valid/ready.
//   state    | meaning
//   ST_IDLE  | empty, ready for an instruction
//   ST_READ  | regfile data returning this cycle
//   ST_VALID | operands held for execute
module regs_operand_fetch
  import regs_operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [31:0]       in_pc,
  output logic              re1,
  output logic              re2,
  output logic [REG_AW-1:0] raddr1,
  output logic [REG_AW-1:0] raddr2,
  input  logic [REG_W-1:0]  rdata1,
  input  logic [REG_W-1:0]  rdata2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic [REG_W-1:0]  wb_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  output logic [4:0]        out_rd,
  output logic [REG_W-1:0]  out_rs1_data,
  output logic [REG_W-1:0]  out_rs2_data
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        w_accept;
  logic        w_load;
  logic        w_snoop;

  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_VALID) && out_ready);
  assign w_accept  = in_valid && in_ready && !flush;
  assign out_valid = (r_state == ST_VALID);
  assign w_load    = (r_state == ST_READ);
  assign w_snoop   = (r_state == ST_VALID);

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_accept) w_state_nxt = ST_READ;
        ST_READ:  w_state_nxt = ST_VALID;
        ST_VALID: if (out_ready) w_state_nxt = w_accept ? ST_READ : ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_inst  <= '0;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_inst <= in_inst;
        r_pc   <= in_pc;
      end
    end
  end

  // Read ports are driven only in the accept cycle.
  assign re1    = w_accept && f_use_rs1(in_inst[6:0]);
  assign re2    = w_accept && f_use_rs2(in_inst[6:0]);
  assign raddr1 = w_accept ? in_inst[19:15] : '0;
  assign raddr2 = w_accept ? in_inst[24:20] : '0;

  assign out_inst = r_inst;
  assign out_pc   = r_pc;
  assign out_rd   = r_inst[11:7];

  operand_resolve u_rs1 (
    .clk        (clk),
    .rst        (rst),
    .i_accept   (w_accept),
    .i_acc_rs   (in_inst[19:15]),
    .i_load     (w_load),
    .i_snoop    (w_snoop),
    .i_rs       (r_inst[19:15]),
    .i_use      (f_use_rs1(r_inst[6:0])),
    .i_rdata    (rdata1),
    .i_wb_we    (wb_we),
    .i_wb_waddr (wb_waddr),
    .i_wb_wdata (wb_wdata),
    .o_data     (out_rs1_data)
  );

  operand_resolve u_rs2 (
    .clk        (clk),
    .rst        (rst),
    .i_accept   (w_accept),
    .i_acc_rs   (in_inst[24:20]),
    .i_load     (w_load),
    .i_snoop    (w_snoop),
    .i_rs       (r_inst[24:20]),
    .i_use      (f_use_rs2(r_inst[6:0])),
    .i_rdata    (rdata2),
    .i_wb_we    (wb_we),
    .i_wb_waddr (wb_waddr),
    .i_wb_wdata (wb_wdata),
    .o_data     (out_rs2_data)
  );

endmodule

// File: tb/tb_regs_operand_fetch.sv
// Bench for regs_operand_fetch: a regfile with old-value-on-same-edge reads,
// an architectural-value model checked every cycle, and directed cases.
module tb_regs_operand_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1 = '0, rdata2 = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst, out_pc;
  logic [4:0]  out_rd;
  logic [31:0] out_rs1_data, out_rs2_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];

  // model: an instruction spends one cycle in the read, then is presented until taken
  logic        m_full = 1'b0;
  int          m_age = 0;
  logic [31:0] m_inst = '0;
  logic [31:0] m_pc = '0;
  logic [31:0] retired_q[$];

  always #5 clk = ~clk;

  regs_operand_fetch dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_rd(out_rd),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data)
  );

  // regfile with no x0 protection, so garbage in x0 is possible
  always @(posedge clk) begin
    if (re1) rdata1 <= regs[raddr1];
    if (re2) rdata2 <= regs[raddr2];
    if (wb_we) regs[wb_waddr] <= wb_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic b_use1(input logic [31:0] inst);
    return !(inst[6:0] == 7'h37 || inst[6:0] == 7'h17 || inst[6:0] == 7'h6F);
  endfunction

  function automatic logic b_use2(input logic [31:0] inst);
    return (inst[6:0] == 7'h33 || inst[6:0] == 7'h23 || inst[6:0] == 7'h63);
  endfunction

  // architecturally current value of an operand
  function automatic logic [31:0] b_opnd(input logic [31:0] inst, input logic second);
    logic [4:0] rs;
    logic       use_it;
    rs     = second ? inst[24:20] : inst[19:15];
    use_it = second ? b_use2(inst) : b_use1(inst);
    return (use_it && rs != 5'd0) ? regs[rs] : 32'd0;
  endfunction

  function automatic logic [31:0] mk_add(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  always @(negedge clk) begin
    logic exp_ready, exp_ov, acc;
    if (rst) begin
      m_full = 1'b0;
      m_age  = 0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    end else begin
      exp_ready = !m_full || (m_age >= 1 && out_ready);
      exp_ov    = m_full && m_age >= 1;
      acc       = in_valid && exp_ready && !flush;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      chk("re1", {31'd0, re1}, {31'd0, acc && b_use1(in_inst)});
      chk("re2", {31'd0, re2}, {31'd0, acc && b_use2(in_inst)});
      chk("raddr1", {27'd0, raddr1}, acc ? {27'd0, in_inst[19:15]} : 32'd0);
      chk("raddr2", {27'd0, raddr2}, acc ? {27'd0, in_inst[24:20]} : 32'd0);
      if (exp_ov) begin
        chk("out_pc", out_pc, m_pc);
        chk("out_inst", out_inst, m_inst);
        chk("out_rd", {27'd0, out_rd}, {27'd0, m_inst[11:7]});
        chk("out_rs1", out_rs1_data, b_opnd(m_inst, 1'b0));
        chk("out_rs2", out_rs2_data, b_opnd(m_inst, 1'b1));
        if (out_ready) retired_q.push_back(m_pc);
      end
      if (flush) begin
        m_full = 1'b0;
      end else if (acc) begin
        m_full = 1'b1;
        m_age  = 0;
        m_inst = in_inst;
        m_pc   = in_pc;
      end else if (exp_ov && out_ready) begin
        m_full = 1'b0;
      end else if (m_full) begin
        m_age++;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_set(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] held_pc;
    step(3);
    @(negedge clk); #2 rst = 1'b0;
    step();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_pc", out_pc, 32'd0);
    chk("reset_out_inst", out_inst, 32'd0);
    chk("reset_rs1", out_rs1_data, 32'd0);

    // preload x5, x6
    wb_set(5'd5, 32'h11); step();
    wb_set(5'd6, 32'h22); step();
    wb_we = 1'b0;

    // basic ADD x7,x5,x6
    chk("add_encoding", mk_add(5'd7, 5'd5, 5'd6), 32'h006283B3);
    in_valid = 1'b1; in_inst = mk_add(5'd7, 5'd5, 5'd6); in_pc = 32'h1000;
    #3;
    chk("basic_re1", {31'd0, re1}, 32'd1);
    chk("basic_raddr1", {27'd0, raddr1}, 32'd5);
    chk("basic_raddr2", {27'd0, raddr2}, 32'd6);
    step(); in_valid = 1'b0;
    step();
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_rs1", out_rs1_data, 32'h11);
    chk("basic_rs2", out_rs2_data, 32'h22);
    chk("basic_rd", {27'd0, out_rd}, 32'd7);
    step();

    // same-edge bypass
    in_valid = 1'b1; in_pc = 32'h1004; wb_set(5'd5, 32'hAA);
    step(); in_valid = 1'b0; wb_we = 1'b0;
    step();
    chk("bypass_rs1", out_rs1_data, 32'hAA);
    chk("bypass_rs2", out_rs2_data, 32'h22);
    step();

    // READ-cycle write, then snoop while held
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h1008;
    step(); in_valid = 1'b0; wb_set(5'd6, 32'hBB);
    step(); wb_we = 1'b0;
    chk("readwr_rs2", out_rs2_data, 32'hBB);
    wb_set(5'd6, 32'hCC);
    step(); wb_we = 1'b0;
    chk("snoop_rs2", out_rs2_data, 32'hCC);
    out_ready = 1'b1;
    step();

    // x0 garbage and unused operands
    wb_set(5'd0, 32'hFF); step();
    in_valid = 1'b1; in_inst = mk_add(5'd1, 5'd0, 5'd0); in_pc = 32'h1100; wb_set(5'd0, 32'h77);
    step(); in_valid = 1'b0; wb_we = 1'b0;
    step();
    chk("x0_rs1", out_rs1_data, 32'd0);
    chk("x0_rs2", out_rs2_data, 32'd0);
    step();
    in_valid = 1'b1; in_inst = 32'h123450B7; in_pc = 32'h1104;
    #3;
    chk("lui_re1", {31'd0, re1}, 32'd0);
    chk("lui_re2", {31'd0, re2}, 32'd0);
    step(); in_valid = 1'b0;
    step();
    chk("lui_rs1", out_rs1_data, 32'd0);
    chk("lui_rs2", out_rs2_data, 32'd0);
    chk("lui_rd", {27'd0, out_rd}, 32'd1);
    step();

    // back-to-back with in_valid held
    retired_q.delete();
    in_inst = mk_add(5'd7, 5'd5, 5'd6);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pc = 32'h2000 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    step(3);
    chk("b2b_count", 32'(retired_q.size()), 32'd5);
    if (retired_q.size() == 5) begin
      chk("b2b_first_pc", retired_q[0], 32'h2000);
      chk("b2b_second_pc", retired_q[1], 32'h2008);
      chk("b2b_last_pc", retired_q[4], 32'h2020);
    end

    // stall for three cycles
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h3000;
    step(); in_pc = 32'h3004;
    step();
    held_pc = out_pc;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_pc_stable", out_pc, 32'h3000);
      step();
    end
    chk("stall_pc_held", held_pc, 32'h3000);
    out_ready = 1'b1;
    step(); in_valid = 1'b0;
    step();
    chk("stall_next_pc", out_pc, 32'h3004);
    step();

    // flush during READ
    in_valid = 1'b1; in_pc = 32'h4000;
    step(); in_valid = 1'b0; flush = 1'b1;
    step(); flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_no_valid", {31'd0, out_valid}, 32'd0);
      step();
    end

    // async reset mid-VALID
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h5000;
    step(); in_valid = 1'b0;
    step();
    chk("prerst_valid", {31'd0, out_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_pc", out_pc, 32'd0);
    chk("async_rst_rs1", out_rs1_data, 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    step();
    out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h5004;
    step(); in_valid = 1'b0;
    step();
    chk("postrst_valid", {31'd0, out_valid}, 32'd1);
    chk("postrst_rs1", out_rs1_data, 32'hAA);
    chk("postrst_rs2", out_rs2_data, 32'hCC);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regs_operand_fetch.md
# regs_operand_fetch

Decode-side operand fetch stage: the requester on the register-file read ports. Accepts one instruction from fetch, decodes rs1/rs2, drives the regfile read ports, captures the operands one cycle later, and holds them for execute under a valid/ready handshake. Corrects the regfile's old-value-on-same-edge behaviour and any later writes by snooping the write-back port, so execute always sees architecturally current operands.

## Interface
Parameters: none. Widths come from the shared defines: `RegBus` (32b data), `RegAddrBus` (5b address), `Enabled`/`Disabled`, `Zero`.

Ports:
- clk  in  1  — the single clock
- rst  in  1  — reset, asynchronous, active-high
- flush  in  1  — discard the held/in-flight instruction
- in_valid  in  1  — fetch offers an instruction
- in_ready  out  1  — the stage can accept
- in_inst  in  32  — instruction word
- in_pc  in  32  — its PC
- re1, re2  out  1 each  — regfile read enables
- raddr1, raddr2  out  `RegAddrBus` each  — regfile read addresses
- rdata1, rdata2  in  `RegBus` each  — regfile read data, valid the cycle after re
- wb_we  in  1  — write-back write enable (same signals as the regfile write port)
- wb_waddr  in  `RegAddrBus`  — write-back address
- wb_wdata  in  `RegBus`  — write-back data
- out_valid  out  1  — operands are valid for execute
- out_ready  in  1  — execute accepts
- out_inst, out_pc  out  32 each  — held instruction and PC
- out_rd  out  5  — inst[11:7]
- out_rs1_data, out_rs2_data  out  `RegBus` each  — resolved operands

## Operation
- rs1 = inst[19:15], rs2 = inst[24:20]. use_rs1 is 0 for LUI (0110111), AUIPC (0010111), and JAL (1101111); otherwise 1. use_rs2 is 1 only for OP (0110011), STORE (0100011), and BRANCH (1100011).
- FSM states:
  - IDLE: in_ready=1.
  - READ: the regfile data arrives this cycle. in_ready=0.
  - VALID: out_valid=1. in_ready=out_ready.
- Accept occurs when in_valid && in_ready && !flush.
  - On accept: latch inst/pc; go to READ.
  - re1=use_rs1, re2=use_rs2, raddr1=rs1, raddr2=rs2. These are combinational in the accept cycle only. Otherwise re=0 and raddr=0.
- Bypass tracking, per operand, in the accept cycle: if wb_we && wb_waddr==rs && rs!=0, set byp=1 and byp_data=wb_wdata. This covers the regfile returning the pre-write value.
- READ → VALID. The operand register loads the first match in this order:
  - rs==0 or operand unused: 0.
  - wb_we && wb_waddr==rs this cycle: wb_wdata.
  - byp: byp_data.
  - Otherwise: rdata.
- VALID:
  - Snoop: wb_we && wb_waddr==rs && rs!=0 && used → the operand register takes wb_wdata.
  - On out_ready: if an accept occurs in the same cycle → READ, else → IDLE.
- Writes to x0 never update an operand. An x0 operand is always 0, even if regs[0] holds garbage.
- flush has priority over all. Next state is IDLE; no accept occurs; re=0. out_valid drops the next cycle.

## Timing
- Reset values: state IDLE, out_valid 0, in_ready 1 once rst deasserts, all out_* data 0, byp flags 0.
- Latency: accept at cycle N, regfile data at N+1, out_valid from N+2.
- Throughput: at most one instruction per 2 cycles (VALID→READ→VALID).
- out_* are registered and stable while out_valid && !out_ready, except for snoop updates to operands.
- Reset asserted mid-operation: the instruction is lost and all outputs return to reset values immediately (asynchronous).

## Structure
- Shared package/defines:
  - RV32I opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_STORE, OPC_BRANCH).
  - The FSM state encoding.
  - Existing `RegBus`/`RegAddrBus`/`Enabled` defines.
- One natural sub-module: `operand_resolve`, instantiated twice (rs1, rs2). It holds the byp flag/data, the priority select in READ, and the VALID snoop for one operand.

## Test plan
- Basic: regs[5]=0x11, regs[6]=0x22; accept ADD x7,x5,x6 → re1=re2=1 and raddr 5/6 in the accept cycle; 2 cycles later out_valid=1, rs1=0x11, rs2=0x22, out_rd=7.
- Same-edge bypass: wb_we writes x5=0xAA in the accept cycle; regfile returns the old value → out_rs1_data=0xAA.
- READ-cycle write: wb writes x6=0xBB during READ → out_rs2_data=0xBB. Hold with out_ready=0 and write x6=0xCC → out_rs2_data becomes 0xCC next cycle.
- x0 and unused: ADD x1,x0,x0 with regs[0] forced to 0xFF → both operands 0. LUI x1 → re1=re2=0, both operands 0.
- Back-to-back and stall: hold in_valid=1, out_ready=1 → out_valid pulses every other cycle with the correct PCs in order. Hold out_ready=0 for 3 cycles → in_ready=0 and outputs stable.
- Flush/reset: flush in READ → IDLE, no out_valid. Async rst pulse mid-VALID → out_valid=0 immediately; next instruction processes normally.
